// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-requester arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    localparam logic [ID_W-1:0] RR_PTR_RST = 3'd7;

    typedef enum logic {IDLE, GRANT} arb_state_t;

endpackage

// File: rtl/arb_prio_sel8.sv
// Combinational winner select: highest set bit wins, searched downward from start_ptr.
// A start_ptr of 7 gives plain fixed priority (bit 7 highest).
module arb_prio_sel8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start_ptr,
    output logic [ID_W-1:0]    win_id,
    output logic               win_valid
);

    logic [ID_W-1:0]      shift;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      rot_id;

    always_comb begin
        // Rotate so that bit start_ptr lands in position 7, encode, then rotate the index back.
        shift     = start_ptr + ID_W'(1);
        req_dbl   = {req, req} >> shift;
        req_rot   = req_dbl[NUM_REQ-1:0];
        rot_id    = '0;
        win_valid = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_rot[i]) begin
                rot_id = ID_W'(i);
            end
        end
        win_id = rot_id + shift;
    end

endmodule

// File: rtl/prio_arbiter_8.sv
// 8-requester arbiter with registered grant, hold-until-release, hold timeout and a turnaround bubble.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority with bit 7 highest.
//
// state | meaning
// IDLE  | no owner; arbitrate req this cycle, outputs all zero
// GRANT | owner grant_id holds the resource until done, request drop or hold limit
module prio_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic               timeout_q, timeout_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic [ID_W-1:0]    start_ptr;
    logic [ID_W-1:0]    win_id;
    logic               win_valid;
    logic               rel_req;
    logic               rel_to;

    arb_prio_sel8 u_sel (
        .req       (req),
        .start_ptr (start_ptr),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    assign start_ptr = ptr_q;

    // The winner just granted becomes the lowest priority for the next search.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_valid) begin
            ptr_d = win_id + ID_W'(7);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= RR_PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start_ptr = RR_PTR_RST;
`endif

    assign rel_req = ~req[grant_id_q];
    assign rel_to  = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_d        = hold_q;
        case (state_q)
            IDLE: begin
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                hold_d        = '0;
                if (win_valid) begin
                    state_d       = GRANT;
                    grant_d       = NUM_REQ'(1) << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (done || rel_req || rel_to) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_id_d    = '0;
                    grant_valid_d = 1'b0;
                    hold_d        = '0;
                    // Flag a timeout only when the hold limit alone ended the grant.
                    timeout_d     = rel_to && !done && !rel_req;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_q        <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_prio_arbiter_8.sv
// Self-checking bench for prio_arbiter_8: directed vector table, rotation sequence, then random traffic vs a reference model.
module tb_prio_arbiter_8;

    localparam int MAX_HOLD = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    always #5 clk = ~clk;

    prio_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, how many cycles it has been shown, search pointer.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 7;
    bit m_to    = 1'b0;

    task automatic model_step(input bit r, input logic [7:0] rq, input bit d);
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 7;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int j = 0; j < 8; j++) begin
                int idx;
                idx = RR ? (m_ptr - j + 8) % 8 : 7 - j;
                if (rq[idx]) begin
                    m_owner = idx;
                    m_held  = 1;
                    m_ptr   = (idx + 7) % 8;
                    break;
                end
            end
        end else if (d || !rq[m_owner]) begin
            m_owner = -1;
            m_to    = 1'b0;
        end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
            m_to = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_exp(input string tag, input bit gv, input logic [2:0] id, input bit to);
        logic [7:0] eg;
        eg = gv ? (8'h01 << id) : 8'h00;
        chk({tag, " grant"}, 32'(grant), 32'(eg));
        chk({tag, " grant_id"}, 32'(grant_id), 32'(gv ? id : 3'd0));
        chk({tag, " grant_valid"}, 32'(grant_valid), 32'(gv));
        chk({tag, " timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic check_model(input string tag);
        check_exp(tag, m_owner >= 0, (m_owner >= 0) ? 3'(m_owner) : 3'd0, m_to);
    endtask

    // Apply inputs, clock once, advance the model, and leave time 1 after the edge for sampling.
    task automatic cyc(input bit r, input logic [7:0] rq, input bit d);
        rst  = r;
        req  = rq;
        done = d;
        @(posedge clk);
        model_step(r, rq, d);
        #1;
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] req;
        bit         done;
        bit         gv;
        logic [2:0] id;
        bit         to;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [7:0] rq;
        bit         d;
        bit         r;
        int         exp_id;

        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;

        // reset then idle
        vt.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0});
        vt.push_back('{1'b0, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0});
        // priority then bubble, no preemption by lower bits
        vt.push_back('{1'b0, 8'h90, 1'b0, 1'b1, 3'd7, 1'b0});
        vt.push_back('{1'b0, 8'h10, 1'b0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0});
        vt.push_back('{1'b0, 8'h10, 1'b0, 1'b1, 3'd4, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        // done release and re-grant
        vt.push_back('{1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0});
        vt.push_back('{1'b0, 8'h40, 1'b1, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0});
        vt.push_back('{1'b0, 8'h40, 1'b0, 1'b1, 3'd6, 1'b0});
        vt.push_back('{1'b0, 8'h40, 1'b1, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        // hold limit of 4 cycles
        for (int i = 0; i < 4; i++) vt.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1});
        vt.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0});
        // done together with the hold limit suppresses timeout
        for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        // mid-grant reset, pointer back to 7
        vt.push_back('{1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0});
        vt.push_back('{1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h09, 1'b0, 1'b1, 3'd3, 1'b0});
        vt.push_back('{1'b0, 8'h89, 1'b0, 1'b1, 3'd3, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        // done in IDLE is ignored
        vt.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0});
        vt.push_back('{1'b0, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0});
        vt.push_back('{1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0});

        foreach (vt[i]) begin
            cyc(vt[i].rst, vt[i].req, vt[i].done);
            check_exp($sformatf("vec%0d", i), vt[i].gv, vt[i].id, vt[i].to);
        end

        // all requesting, done pulsed on every grant
        cyc(1'b1, 8'hFF, 1'b0);
        check_exp("rot_reset", 1'b0, 3'd0, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            exp_id = RR ? (15 - k) % 8 : 7;
            cyc(1'b0, 8'hFF, 1'b0);
            check_exp($sformatf("rot_grant%0d", k), 1'b1, 3'(exp_id), 1'b0);
            cyc(1'b0, 8'hFF, 1'b1);
            check_exp($sformatf("rot_bubble%0d", k), 1'b0, 3'd0, 1'b0);
        end

        // random traffic with sticky requests so hold limits are reached
        rq = 8'h00;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(7) == 0) begin
                rq = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            end
            d = ($urandom_range(5) == 0);
            r = ($urandom_range(99) == 0);
            cyc(r, rq, d);
            check_model($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_8.md
Name: prio_arbiter_8

Overview:
- Sequential 8-requester arbiter that shares one downstream resource (bus, engine port) between eight requesters.
- Winner selection reuses the team's 8-bit priority encoding: highest set bit wins, encoded as a 3-bit index plus a valid flag.
- Adds grant registering, grant hold until release, hold-time timeout and a one-cycle turnaround bubble.
- Sits between requester agents and the shared resource's select mux.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant is held; 0 disables the timeout.
- HOLD_W, $clog2(MAX_HOLD+1) with a minimum of 1: width of the hold counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current owner finished; sampled only in GRANT.
- grant  output  8  one-hot grant, registered.
- grant_id  output  3  index of the current owner, registered.
- grant_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values:
  - grant = 8'h00, grant_id = 3'd0, grant_valid = 0, timeout = 0.
  - hold counter = 0, state = IDLE, rr pointer = 3'd7.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req != 0: latch the winner and go to GRANT.
  - Outputs become visible the cycle after req is sampled, so request-to-grant latency is 1 cycle.
  - grant = 1 << winner, grant_id = winner, grant_valid = 1, hold counter = 0.
  - If req == 0: stay in IDLE with all outputs 0.
- GRANT: each cycle evaluate the release conditions in this priority order:
  - (a) done = 1.
  - (b) req[grant_id] = 0.
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD-1.
  - On any release: go to IDLE and clear grant, grant_id and grant_valid next cycle.
  - timeout = 1 for that one cycle only when (c) is the sole cause. If (a) or (b) is also true, timeout = 0.
  - Otherwise increment the hold counter, which saturates at MAX_HOLD-1.
- Turnaround:
  - After any release grant_valid is 0 for exactly one cycle (the IDLE cycle). No back-to-back grants.
  - Minimum grant period is 1 cycle, so 2 cycles per ownership change.
- A timed-out requester that still asserts req re-enters arbitration normally.
  - Under fixed priority it may win again.
- done asserted in IDLE is ignored.
- Requests for bits other than grant_id during GRANT are ignored; there is no preemption.
- grant is always one-hot or zero. grant_id is 0 whenever grant_valid = 0.
- A reset asserted mid-grant takes effect at the next edge: all state returns to reset values, with no timeout pulse.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. The search order is ptr, ptr-1, ..., wrapping modulo 8.
  - On each grant to index k, ptr becomes (k+7) mod 8, so k becomes lowest priority.
  - ptr resets to 7, so the first arbitration equals fixed priority.
- Undefined:
  - Fixed priority, bit 7 highest, bit 0 lowest.
  - The rr pointer register is not instantiated.

Decomposition:
- Shared package arb_pkg holds:
  - localparam NUM_REQ = 8, ID_W = 3.
  - typedef enum logic {IDLE, GRANT} arb_state_t.
  - The reset value of the rr pointer.
- One natural sub-module, arb_prio_sel8 (combinational):
  - Inputs: req[7:0], start_ptr[2:0].
  - Outputs: win_id[2:0], win_valid.
  - Rotates req right by start_ptr+1 to 7, priority-encodes with the highest bit winning, then rotates the index back.
  - In fixed mode start_ptr is tied to 7.

Test Plan:
- Reset then idle: hold rst 2 cycles with req = 8'hFF -> all outputs 0 during reset; first cycle after deassert still 0; grant_id = 7, grant = 8'h80, grant_valid = 1 the following cycle.
- Fixed priority (macro off): req = 8'b1001_0000 -> grant_id = 7. Drop req[7] -> one bubble cycle with grant_valid = 0, then grant_id = 4, grant = 8'h10.
- done release: owner 6 asserts done for 1 cycle with req held -> grant_valid = 0 next cycle, timeout = 0, then re-grant to 6 (fixed mode).
- Timeout with MAX_HOLD = 4: req = 8'h01 held, done = 0 -> grant_valid high 4 cycles, timeout pulse on the release cycle, 1 bubble, re-grant to 0.
- Round robin (macro on): req = 8'hFF held, done pulsed each grant -> grant_id sequence 7, 6, 5, ..., 0, 7 with a bubble between each.
- Mid-grant reset: grant to 3 active, assert rst 1 cycle -> next cycle grant = 0, grant_valid = 0, timeout = 0; the rr pointer is back to 7, so the next arbitration of req = 8'h09 gives grant_id = 3.
